// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with a response watchdog.
// Define YSYX_23060201_ARB_RR_EN for round-robin tie-breaking; otherwise the LSU wins ties.
module ysyx_23060201_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [ADDR_W-1:0]     m0_addr,
  output logic                  m0_resp_valid,
  input  logic                  m0_resp_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_resp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic                  m1_wen,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wmask,
  output logic                  m1_resp_valid,
  input  logic                  m1_resp_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_resp_err,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_wen,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wmask,
  input  logic                  s_resp_valid,
  output logic                  s_resp_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  owner
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSreq, StSresp, StMresp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                grant1;
  logic                timeout;
  logic                run;

`ifdef YSYX_23060201_ARB_RR_EN
  logic fav_q, fav_d;  // 1: m1 wins the next tie
  assign grant1 = m1_req_valid & (~m0_req_valid | fav_q);
`else
  assign grant1 = m1_req_valid;
`endif

  // Reset wins over every handshake, so no ready/valid is offered while it is high.
  assign run     = ~rst;
  assign timeout = (cnt_q == TimeoutCnt);

  assign m0_req_ready  = run & (state_q == StIdle) & m0_req_valid & ~grant1;
  assign m1_req_ready  = run & (state_q == StIdle) & grant1;
  assign s_req_valid   = run & (state_q == StSreq);
  assign s_resp_ready  = run & (state_q == StSresp);
  assign m0_resp_valid = run & (state_q == StMresp) & ~owner_q;
  assign m1_resp_valid = run & (state_q == StMresp) & owner_q;
  assign m0_resp_err   = m0_resp_valid & err_q;
  assign m1_resp_err   = m1_resp_valid & err_q;
  assign m0_rdata      = rdata_q;
  assign m1_rdata      = rdata_q;
  assign s_addr        = addr_q;
  assign s_wen         = wen_q;
  assign s_wdata       = wdata_q;
  assign s_wmask       = wmask_q;
  assign owner         = owner_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef YSYX_23060201_ARB_RR_EN
    fav_d   = fav_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req_valid | m1_req_valid) begin
          owner_d = grant1;
          addr_d  = grant1 ? m1_addr : m0_addr;
          wen_d   = grant1 & m1_wen;
          wdata_d = grant1 ? m1_wdata : '0;
          wmask_d = grant1 ? m1_wmask : '0;
          cnt_d   = '0;
          state_d = StSreq;
`ifdef YSYX_23060201_ARB_RR_EN
          fav_d   = ~grant1;
`endif
        end
      end
      StSreq: begin
        // Saturate so a late request handshake still times out in SRESP.
        cnt_d = timeout ? cnt_q : cnt_q + 8'd1;
        if (s_req_ready) begin
          state_d = StSresp;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StMresp;
        end
      end
      StSresp: begin
        cnt_d = timeout ? cnt_q : cnt_q + 8'd1;
        if (s_resp_valid) begin
          rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = StMresp;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StMresp;
        end
      end
      StMresp: begin
        if (owner_q ? m1_resp_ready : m0_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_23060201_ARB_RR_EN
      fav_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef YSYX_23060201_ARB_RR_EN
      fav_q   <= fav_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Bench for ysyx_23060201_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_ysyx_23060201_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready, m0_resp_err;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_resp_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready, owner;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  always #5 clk = ~clk;

  ysyx_23060201_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata),
    .owner(owner)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: stage 0 waiting, 1 offered to slave, 2 awaiting slave, 3 returning.
  int          stage = 0;
  int          elapsed = 0;
  logic        t_owner = 1'b0, t_wen = 1'b0, t_err = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
  logic [3:0]  t_wmask = '0;
  logic        fav1 = 1'b0;
  logic        mon_en = 1'b0;
  logic        hs0 = 1'b0, hs1 = 1'b0;
  logic        any_req, win1;

  always @(negedge clk) begin
    if (mon_en) begin
      any_req = m0_req_valid | m1_req_valid;
      if (m0_req_valid && m1_req_valid) begin
`ifdef YSYX_23060201_ARB_RR_EN
        win1 = fav1;
`else
        win1 = 1'b1;
`endif
      end else begin
        win1 = m1_req_valid;
      end
      check("m0_req_ready", m0_req_ready, !rst && stage == 0 && any_req && !win1);
      check("m1_req_ready", m1_req_ready, !rst && stage == 0 && any_req && win1);
      check("s_req_valid", s_req_valid, !rst && stage == 1);
      check("s_resp_ready", s_resp_ready, !rst && stage == 2);
      check("m0_resp_valid", m0_resp_valid, !rst && stage == 3 && !t_owner);
      check("m1_resp_valid", m1_resp_valid, !rst && stage == 3 && t_owner);
      check("m0_resp_err", m0_resp_err, !rst && stage == 3 && !t_owner && t_err);
      check("m1_resp_err", m1_resp_err, !rst && stage == 3 && t_owner && t_err);
      check("owner", owner, t_owner);
      if (stage == 1) begin
        check("s_addr", s_addr, t_addr);
        check("s_wen", s_wen, t_wen);
        check("s_wdata", s_wdata, t_wdata);
        check("s_wmask", s_wmask, t_wmask);
      end
      if (stage == 3) check("rdata", t_owner ? m1_rdata : m0_rdata, t_rdata);
      hs0 = m0_req_valid & m0_req_ready;
      hs1 = m1_req_valid & m1_req_ready;

      if (rst) begin
        stage = 0; elapsed = 0; t_owner = 0; t_rdata = '0; t_err = 0; fav1 = 0;
      end else begin
        case (stage)
          0: if (any_req) begin
            t_owner = win1;
            t_addr  = win1 ? m1_addr : m0_addr;
            t_wen   = win1 && m1_wen;
            t_wdata = win1 ? m1_wdata : 32'h0;
            t_wmask = win1 ? m1_wmask : 4'h0;
            fav1    = !win1;
            elapsed = 0;
            stage   = 1;
          end
          1: begin
            if (s_req_ready) stage = 2;
            else if (elapsed >= TO) begin t_rdata = '0; t_err = 1; stage = 3; end
            elapsed++;
          end
          2: begin
            if (s_resp_valid) begin t_rdata = s_rdata; t_err = 0; stage = 3; end
            else if (elapsed >= TO) begin t_rdata = '0; t_err = 1; stage = 3; end
            elapsed++;
          end
          default: if (t_owner ? m1_resp_ready : m0_resp_ready) stage = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req_valid = 0; m0_addr = '0; m0_resp_ready = 0;
    m1_req_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    m1_resp_ready = 0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); tick(); tick(); rst = 0;
  endtask

  task automatic drain();
    clear_inputs();
    s_req_ready = 1; s_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  int   lat, ng, cyc;
  logic order [4];
  logic seen;

  initial begin
    rst = 1; clear_inputs();
    tick();
    mon_en = 1;
    m0_req_valid = 1; m1_req_valid = 1;
    tick();
    #1;
    check("rst m0_req_ready", m0_req_ready, 0);
    check("rst m1_req_ready", m1_req_ready, 0);
    check("rst s_req_valid", s_req_valid, 0);
    check("rst m0_rdata", m0_rdata, 0);
    check("rst owner", owner, 0);
    tick();
    rst = 0; clear_inputs();

    // Single IFU read, minimum latency.
    m0_req_valid = 1; m0_addr = 32'h8000_0000; s_req_ready = 1; m0_resp_ready = 1;
    #1 check("t1 accept", m0_req_ready, 1);
    tick(); m0_req_valid = 0; m0_addr = 32'h0;
    #1 check("t1 s_addr", s_addr, 32'h8000_0000);
    check("t1 s_wen", s_wen, 0);
    tick(); s_resp_valid = 1; s_rdata = 32'h0000_0413;
    #1 check("t1 s_resp_ready", s_resp_ready, 1);
    tick(); s_resp_valid = 0; s_rdata = 32'hffff_ffff;
    #1 check("t1 m0_resp_valid", m0_resp_valid, 1);
    check("t1 m0_rdata", m0_rdata, 32'h0000_0413);
    check("t1 m0_resp_err", m0_resp_err, 0);
    check("t1 owner", owner, 0);
    check("t1 m1_resp_valid", m1_resp_valid, 0);
    tick();
    #1 check("t1 done", m0_resp_valid, 0);

    // LSU write with three slave-ready stall cycles.
    clear_inputs();
    m1_req_valid = 1; m1_addr = 32'h8000_1000; m1_wen = 1; m1_wdata = 32'hDEAD_BEEF;
    m1_wmask = 4'hF; s_resp_valid = 1; s_rdata = 32'h0BAD_F00D; m1_resp_ready = 1;
    #1 check("t2 accept", m1_req_ready, 1);
    lat = 0;
    do begin
      tick(); lat++;
      m1_req_valid = 0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0; m1_addr = '0;
      s_req_ready = (lat >= 4);
      #1;
      if (lat == 2) begin
        check("t2 s_addr", s_addr, 32'h8000_1000);
        check("t2 s_wdata", s_wdata, 32'hDEAD_BEEF);
        check("t2 s_wmask", s_wmask, 4'hF);
      end
    end while (!m1_resp_valid && lat < 40);
    check("t2 latency", lat, 6);
    tick();

    // Tie between masters for four back-to-back transactions.
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h1000; m1_req_valid = 1; m1_addr = 32'h2000;
    s_req_ready = 1; s_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      #1;
      if (m0_req_ready) begin order[ng] = 0; ng++; end
      else if (m1_req_ready) begin order[ng] = 1; ng++; end
      tick(); cyc++;
    end
    check("t3 grants", ng, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060201_ARB_RR_EN
      check("t3 grant order", order[i], (i % 2 == 0) ? 0 : 1);
`else
      check("t3 grant order", order[i], 1);
`endif
    end
    drain();

    // Hung slave: watchdog error, then a normal read.
    clear_inputs();
    m1_req_valid = 1; m1_addr = 32'h8000_2000; s_req_ready = 1; m1_resp_ready = 1;
    s_rdata = 32'h5555_5555;
    #1 check("t4 accept", m1_req_ready, 1);
    lat = 0;
    do begin tick(); lat++; m1_req_valid = 0; #1; end while (!m1_resp_valid && lat < 40);
    check("t4 latency", lat, TO + 2);
    check("t4 err", m1_resp_err, 1);
    check("t4 rdata", m1_rdata, 0);
    tick();
    m0_req_valid = 1; m0_addr = 32'h8000_0004; s_resp_valid = 1; s_rdata = 32'h1234_ABCD;
    m0_resp_ready = 1;
    lat = 0;
    do begin tick(); lat++; m0_req_valid = 0; #1; end while (!m0_resp_valid && lat < 40);
    check("t4 next latency", lat, 3);
    check("t4 next rdata", m0_rdata, 32'h1234_ABCD);
    check("t4 next err", m0_resp_err, 0);
    tick();

    // IFU holds off its response for five cycles while the LSU waits.
    clear_inputs();
    m0_req_valid = 1; m0_addr = 32'h8000_0008; s_req_ready = 1; s_resp_valid = 1;
    s_rdata = 32'hCAFE_F00D;
    #1 check("t5 accept", m0_req_ready, 1);
    tick(); m0_req_valid = 0; m1_req_valid = 1; m1_addr = 32'h8000_3000;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      s_rdata = $urandom;
      #1;
      check("t5 held valid", m0_resp_valid, 1);
      check("t5 held rdata", m0_rdata, 32'hCAFE_F00D);
      check("t5 no grant", m1_req_ready, 0);
      tick();
    end
    m0_resp_ready = 1;
    #1 check("t5 release", m0_resp_valid, 1);
    tick(); m0_resp_ready = 0;
    #1 check("t5 next grant", m1_req_ready, 1);
    drain();

    // Reset while waiting for the slave response.
    clear_inputs();
    m1_req_valid = 1; m1_addr = 32'h8000_4000; s_req_ready = 1; m1_resp_ready = 1;
    #1 check("t6 accept", m1_req_ready, 1);
    tick(); m1_req_valid = 0;
    tick();
    #1 check("t6 in sresp", s_resp_ready, 1);
    rst = 1; s_resp_valid = 1; s_rdata = 32'h7777_7777;
    tick(); rst = 0; s_resp_valid = 0;
    #1;
    check("t6 s_req_valid", s_req_valid, 0);
    check("t6 s_resp_ready", s_resp_ready, 0);
    check("t6 m1_resp_err", m1_resp_err, 0);
    check("t6 m1_rdata", m1_rdata, 0);
    check("t6 owner", owner, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | m1_resp_valid | m0_resp_valid;
      tick();
    end
    check("t6 no response", seen, 0);

    // Randomized traffic with protocol-respecting masters.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req_valid || hs0) begin
        m0_req_valid = ($urandom % 3) != 0;
        m0_addr = $urandom;
      end
      if (!m1_req_valid || hs1) begin
        m1_req_valid = ($urandom % 3) != 0;
        m1_addr = $urandom; m1_wen = $urandom % 2; m1_wdata = $urandom;
        m1_wmask = 4'($urandom);
      end
      m0_resp_ready = ($urandom % 4) != 0;
      m1_resp_ready = ($urandom % 4) != 0;
      s_req_ready = ($urandom % 3) != 0;
      s_resp_valid = ($urandom % 3) == 0;
      s_rdata = $urandom;
      rst = ($urandom % 400) == 0;
      tick();
    end
    rst = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_23060201_mem_arbiter.md
# ysyx_23060201_mem_arbiter

Two-master, one-slave memory arbiter between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write), and the single physical memory port. It accepts one request at a time, forwards it to the slave over a valid/ready handshake, and routes the response back to the owning master. A watchdog counter turns a hung slave into an error response. The block sits between IFU/LSU and the memory wrapper that calls the DPI-C memory functions.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask is DATA_W/8 bits
- TIMEOUT, 255, max cycles from request acceptance to slave response before error; must be ≥2, fits in 8 bits
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- m0_req_valid / m0_req_ready  in / out  1  IFU request handshake
- m0_addr  input  ADDR_W  IFU fetch address
- m0_resp_valid / m0_resp_ready  out / in  1  IFU response handshake
- m0_rdata  output  DATA_W  fetched instruction
- m0_resp_err  output  1  IFU response is a timeout
- m1_req_valid / m1_req_ready  in / out  1  LSU request handshake
- m1_addr  input  ADDR_W;  m1_wen  input  1;  m1_wdata  input  DATA_W;  m1_wmask  input  DATA_W/8
- m1_resp_valid / m1_resp_ready  out / in  1  LSU response handshake
- m1_rdata  output  DATA_W;  m1_resp_err  output  1
- s_req_valid / s_req_ready  out / in  1  slave request handshake
- s_addr  output  ADDR_W;  s_wen  output  1;  s_wdata  output  DATA_W;  s_wmask  output  DATA_W/8
- s_resp_valid / s_resp_ready  in / out  1  slave response handshake
- s_rdata  input  DATA_W
- owner  output  1  master owning the current transaction (0 = IFU, 1 = LSU); valid outside IDLE

## Operation
- States: IDLE, SREQ, SRESP, MRESP.
- IDLE: grant one requesting master. mX_req_ready = (state==IDLE) & mX_req_valid & grant_X, so it is combinational on valid and at most one is high. On accept, latch addr/wen/wdata/wmask and owner, clear the counter, go to SREQ. m0 requests latch wen=0, wmask=0, wdata=0.
- SREQ: drive s_req_valid=1 with the latched fields, held stable until s_req_ready. On s_req_ready go to SRESP.
- SRESP: drive s_resp_ready=1. On s_resp_valid, latch s_rdata, set err=0, go to MRESP.
- Watchdog (SREQ and SRESP): the counter increments each cycle. When it equals TIMEOUT and no handshake completes in that cycle, latch rdata=0 and err=1, then go to MRESP.
- MRESP: the owner's resp_valid=1, with rdata/err held stable. The other master's resp_valid stays 0. On the owner's resp_ready, go to IDLE.
- Responses to writes carry rdata = s_rdata as returned by the slave; masters ignore it.
- s_resp_ready is 0 outside SRESP. A slave response arriving after a timeout is not absorbed; the slave must be reset.
- Grant policy is set by the Configuration section.

## Timing
- Reset values: state=IDLE; counter=0; all mX_req_ready, mX_resp_valid, s_req_valid, s_resp_ready, mX_resp_err = 0; mX_rdata = 0; owner = 0. The round-robin pointer points to m0.
- rst has priority over all handshakes. Reset mid-transaction abandons it: next cycle is IDLE with reset values, and no response is delivered.
- Minimum transaction is 4 cycles from one accept to the next: C0 accept (IDLE) → C1 SREQ with s_req_ready → C2 SRESP with s_resp_valid → C3 MRESP with resp_ready → C4 IDLE, next accept possible.
- Each extra slave-ready or slave-response wait cycle adds 1 cycle. Master backpressure in MRESP adds 1 cycle per cycle.
- Timeout: MRESP is entered on the cycle after counter==TIMEOUT (TIMEOUT+1 cycles after entering SREQ).
- Simultaneous m0/m1 valid in IDLE: exactly one is granted. The loser's valid is held by the master (AXI-style rule: valid, once high, is not dropped before ready).

## Configuration
- YSYX_23060201_ARB_RR_EN defined: round-robin. On a tie, grant the master not granted last. The pointer updates on each accept and is reset to favour m0.
- Not defined: fixed priority, m1 (LSU) always wins ties. There is no pointer register.
- A single requester is granted immediately in both modes.

## Test plan
- Single IFU read, slave ready immediately and responds next cycle with 0x00000413: m0_resp_valid at C3, m0_rdata=0x00000413, err=0, owner=0, m1_resp_valid stays 0.
- LSU write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, slave stalls s_req_ready for 3 cycles: s_addr/s_wdata/s_wmask are stable throughout, and m1_resp_valid arrives exactly 3 cycles later than the minimum.
- m0 and m1 valid together for 4 back-to-back transactions: with RR_EN the grant order is m0, m1, m0, m1; without it, all m1 grants come first.
- Slave never asserts s_resp_valid, TIMEOUT=8: m1_resp_valid=1 with err=1 and rdata=0 after 9 cycles in SREQ/SRESP; the next request proceeds normally.
- Master backpressure: m0_resp_ready low for 5 cycles in MRESP. rdata/err are held, and no new grant happens until the handshake completes.
- rst pulsed while in SRESP: next cycle all outputs are at reset values and state is IDLE; no response is delivered to the owner.
